// File: rtl/nabp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nabp_pkg                                                                   |
// | Shared encodings and default angle constants for the NABP angle sequencer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nabp_pkg;

    localparam int unsigned c_angle_length_def = 9;
    localparam int unsigned c_angle_step_def   = 1;
    localparam int unsigned c_angle_45_def     = 45;
    localparam int unsigned c_angle_90_def     = 90;
    localparam int unsigned c_angle_135_def    = 135;
    localparam int unsigned c_angle_180_def    = 180;

    typedef enum logic [1:0] {
        SECTOR_A = 2'd0,
        SECTOR_B = 2'd1,
        SECTOR_C = 2'd2,
        SECTOR_D = 2'd3
    } sector_e;

    typedef enum logic {
        SCAN_X = 1'b0,
        SCAN_Y = 1'b1
    } scan_mode_e;

    typedef enum logic {
        SCAN_FWD = 1'b0,
        SCAN_BWD = 1'b1
    } scan_dir_e;

    typedef enum logic {
        BUFF_TAN = 1'b0,
        BUFF_COT = 1'b1
    } buff_mode_e;

    typedef enum logic {
        BUFF_ASC  = 1'b0,
        BUFF_DESC = 1'b1
    } buff_dir_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/nabp_angle_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nabp_angle_sequencer_if                                                    |
// | Angle/mode issue bundle and per-angle completion between sequencer/swaths. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface nabp_angle_sequencer_if
    import nabp_pkg::*;
#(
    parameter int unsigned ANGLE_LENGTH = c_angle_length_def
);
    logic                    issue_valid;
    logic                    issue_ready;
    logic [ANGLE_LENGTH-1:0] angle;
    logic [1:0]              sector;
    logic                    scan_mode;
    logic                    scan_direction;
    logic                    buff_step_mode;
    logic                    buff_step_direction;
    logic                    sector_change;
    logic                    proj_done;

    modport master (
        output issue_valid, angle, sector, scan_mode, scan_direction,
               buff_step_mode, buff_step_direction, sector_change,
        input  issue_ready, proj_done
    );

    modport slave (
        input  issue_valid, angle, sector, scan_mode, scan_direction,
               buff_step_mode, buff_step_direction, sector_change,
        output issue_ready, proj_done
    );
endinterface
`default_nettype wire

// File: rtl/nabp_mode_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nabp_mode_decode                                                           |
// | Combinational angle -> sector and scan/buffer mode decode.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nabp_mode_decode
    import nabp_pkg::*;
#(
    parameter int unsigned ANGLE_LENGTH = c_angle_length_def,
    parameter int unsigned ANGLE_45     = c_angle_45_def,
    parameter int unsigned ANGLE_90     = c_angle_90_def,
    parameter int unsigned ANGLE_135    = c_angle_135_def
) (
    input  wire [ANGLE_LENGTH-1:0] angle_i,
    output logic [1:0]             sector_o,
    output logic                   scan_mode_o,
    output logic                   scan_direction_o,
    output logic                   buff_step_mode_o,
    output logic                   buff_step_direction_o
);

    localparam logic [ANGLE_LENGTH:0] c_angle_45  = ANGLE_45[ANGLE_LENGTH:0];
    localparam logic [ANGLE_LENGTH:0] c_angle_90  = ANGLE_90[ANGLE_LENGTH:0];
    localparam logic [ANGLE_LENGTH:0] c_angle_135 = ANGLE_135[ANGLE_LENGTH:0];

    logic [ANGLE_LENGTH:0] w_angle_ext;
    sector_e               w_sector;

    assign w_angle_ext = {1'b0, angle_i};

    always_comb begin
        w_sector = SECTOR_D;
        if (w_angle_ext < c_angle_45) begin
            w_sector = SECTOR_A;
        end else if (w_angle_ext < c_angle_90) begin
            w_sector = SECTOR_B;
        end else if (w_angle_ext < c_angle_135) begin
            w_sector = SECTOR_C;
        end
    end

    always_comb begin
        scan_mode_o           = SCAN_X;
        scan_direction_o      = SCAN_FWD;
        buff_step_mode_o      = BUFF_TAN;
        buff_step_direction_o = BUFF_ASC;
        case (w_sector)
            SECTOR_A: begin
            end
            SECTOR_B: begin
                scan_mode_o           = SCAN_Y;
                buff_step_mode_o      = BUFF_COT;
                buff_step_direction_o = BUFF_DESC;
            end
            SECTOR_C: begin
                scan_mode_o           = SCAN_Y;
                scan_direction_o      = SCAN_BWD;
                buff_step_mode_o      = BUFF_COT;
                buff_step_direction_o = BUFF_DESC;
            end
            default: begin
                scan_direction_o      = SCAN_BWD;
                buff_step_direction_o = BUFF_DESC;
            end
        endcase
    end

    assign sector_o = w_sector;

endmodule
`default_nettype wire

// File: rtl/nabp_angle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nabp_angle_sequencer                                                       |
// | Steps the projection angle through the sweep and issues per-angle modes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nabp_angle_sequencer
    import nabp_pkg::*;
#(
    parameter int unsigned ANGLE_LENGTH = c_angle_length_def,
    parameter int unsigned ANGLE_STEP   = c_angle_step_def,
    parameter int unsigned ANGLE_45     = c_angle_45_def,
    parameter int unsigned ANGLE_90     = c_angle_90_def,
    parameter int unsigned ANGLE_135    = c_angle_135_def,
    parameter int unsigned ANGLE_180    = c_angle_180_def
) (
    input  wire                    clk,
    input  wire                    reset,
    input  wire                    start_i,
    input  wire                    abort_i,
    output logic                   busy_o,
    output logic                   sweep_done_o,
    output logic                   aborted_o,
    nabp_angle_sequencer_if.master iss
);

    localparam logic [ANGLE_LENGTH:0] c_angle_step = ANGLE_STEP[ANGLE_LENGTH:0];
    localparam logic [ANGLE_LENGTH:0] c_angle_180  = ANGLE_180[ANGLE_LENGTH:0];

    seq_state_e              state_q, state_d;
    logic [ANGLE_LENGTH-1:0] angle_q, angle_d;
    logic [1:0]              sector_q, sector_d;
    logic [1:0]              prev_sector_q, prev_sector_d;
    logic                    scan_mode_q, scan_mode_d;
    logic                    scan_dir_q, scan_dir_d;
    logic                    buff_mode_q, buff_mode_d;
    logic                    buff_dir_q, buff_dir_d;
    logic                    sector_change_q, sector_change_d;
    logic                    first_q, first_d;
    logic                    busy_q, busy_d;
    logic                    sweep_done_q, sweep_done_d;
    logic                    aborted_q, aborted_d;

    logic [1:0]              w_dec_sector;
    logic                    w_dec_scan_mode;
    logic                    w_dec_scan_dir;
    logic                    w_dec_buff_mode;
    logic                    w_dec_buff_dir;
    logic [ANGLE_LENGTH:0]   w_next_angle;

    nabp_mode_decode #(
        .ANGLE_LENGTH (ANGLE_LENGTH),
        .ANGLE_45     (ANGLE_45),
        .ANGLE_90     (ANGLE_90),
        .ANGLE_135    (ANGLE_135)
    ) u_mode_decode (
        .angle_i               (angle_q),
        .sector_o              (w_dec_sector),
        .scan_mode_o           (w_dec_scan_mode),
        .scan_direction_o      (w_dec_scan_dir),
        .buff_step_mode_o      (w_dec_buff_mode),
        .buff_step_direction_o (w_dec_buff_dir)
    );

    // One extra bit so the end-of-sweep compare never sees a wrapped angle.
    assign w_next_angle = {1'b0, angle_q} + c_angle_step;

    always_comb begin
        state_d         = state_q;
        angle_d         = angle_q;
        sector_d        = sector_q;
        prev_sector_d   = prev_sector_q;
        scan_mode_d     = scan_mode_q;
        scan_dir_d      = scan_dir_q;
        buff_mode_d     = buff_mode_q;
        buff_dir_d      = buff_dir_q;
        sector_change_d = sector_change_q;
        first_d         = first_q;
        busy_d          = busy_q;
        sweep_done_d    = 1'b0;
        aborted_d       = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start_i) begin
                angle_d = '0;
                first_d = 1'b1;
                busy_d  = 1'b1;
                state_d = ST_SETUP;
            end
        end else if (abort_i) begin
            // Abort outranks a same-cycle handshake or completion.
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                ST_SETUP: begin
                    sector_d        = w_dec_sector;
                    scan_mode_d     = w_dec_scan_mode;
                    scan_dir_d      = w_dec_scan_dir;
                    buff_mode_d     = w_dec_buff_mode;
                    buff_dir_d      = w_dec_buff_dir;
                    sector_change_d = first_q || (w_dec_sector != prev_sector_q);
                    state_d         = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (iss.issue_ready) begin
                        prev_sector_d = sector_q;
                        first_d       = 1'b0;
                        state_d       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (iss.proj_done) begin
                        if (w_next_angle >= c_angle_180) begin
                            sweep_done_d = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = ST_IDLE;
                        end else begin
                            angle_d = w_next_angle[ANGLE_LENGTH-1:0];
                            state_d = ST_SETUP;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            angle_q         <= '0;
            sector_q        <= SECTOR_A;
            prev_sector_q   <= SECTOR_A;
            scan_mode_q     <= SCAN_X;
            scan_dir_q      <= SCAN_FWD;
            buff_mode_q     <= BUFF_TAN;
            buff_dir_q      <= BUFF_ASC;
            sector_change_q <= 1'b0;
            first_q         <= 1'b0;
            busy_q          <= 1'b0;
            sweep_done_q    <= 1'b0;
            aborted_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            angle_q         <= angle_d;
            sector_q        <= sector_d;
            prev_sector_q   <= prev_sector_d;
            scan_mode_q     <= scan_mode_d;
            scan_dir_q      <= scan_dir_d;
            buff_mode_q     <= buff_mode_d;
            buff_dir_q      <= buff_dir_d;
            sector_change_q <= sector_change_d;
            first_q         <= first_d;
            busy_q          <= busy_d;
            sweep_done_q    <= sweep_done_d;
            aborted_q       <= aborted_d;
        end
    end

    assign iss.issue_valid         = (state_q == ST_ISSUE);
    assign iss.angle               = angle_q;
    assign iss.sector              = sector_q;
    assign iss.scan_mode           = scan_mode_q;
    assign iss.scan_direction      = scan_dir_q;
    assign iss.buff_step_mode      = buff_mode_q;
    assign iss.buff_step_direction = buff_dir_q;
    assign iss.sector_change       = sector_change_q && (state_q == ST_ISSUE);

    assign busy_o       = busy_q;
    assign sweep_done_o = sweep_done_q;
    assign aborted_o    = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_nabp_angle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nabp_angle_sequencer                                                    |
// | Scoreboard bench: 9-bit/step-1 sweep plus an 8-bit/step-7 sweep.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_nabp_angle_sequencer;

    typedef struct packed {
        logic [8:0] angle;
        logic [1:0] sector;
        logic       sm;
        logic       sd;
        logic       bm;
        logic       bd;
        logic       sc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort, busy, sweep_done, aborted;
    logic reset7, start7, abort7, busy7, sweep_done7, aborted7;

    nabp_angle_sequencer_if #(.ANGLE_LENGTH(9)) bus ();
    nabp_angle_sequencer_if #(.ANGLE_LENGTH(8)) bus7 ();

    nabp_angle_sequencer #(.ANGLE_LENGTH(9), .ANGLE_STEP(1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .abort_i      (abort),
        .busy_o       (busy),
        .sweep_done_o (sweep_done),
        .aborted_o    (aborted),
        .iss          (bus.master)
    );

    nabp_angle_sequencer #(.ANGLE_LENGTH(8), .ANGLE_STEP(7)) u_dut7 (
        .clk          (clk),
        .reset        (reset7),
        .start_i      (start7),
        .abort_i      (abort7),
        .busy_o       (busy7),
        .sweep_done_o (sweep_done7),
        .aborted_o    (aborted7),
        .iss          (bus7.master)
    );

    exp_t q[$];
    exp_t q7[$];
    int   checks = 0;
    int   errors = 0;
    int   sd_cnt = 0, ab_cnt = 0, sd7_cnt = 0, n7 = 0;
    int   pd_cnt7 = 0;

    // Hand-computed decode at the sector boundaries: {sector, sm, sd, bm, bd}
    int         tbl_a [7] = '{44, 45, 89, 90, 134, 135, 179};
    logic [5:0] tbl_v [7] = '{6'b00_0000, 6'b01_1011, 6'b01_1011, 6'b10_1111,
                              6'b10_1111, 6'b11_0101, 6'b11_0101};

    function automatic exp_t model(input int a);
        exp_t e;
        logic [3:0] m;
        e.angle = 9'(a);
        if (a < 45)       e.sector = 2'd0;
        else if (a < 90)  e.sector = 2'd1;
        else if (a < 135) e.sector = 2'd2;
        else              e.sector = 2'd3;
        case (e.sector)
            2'd0:    m = 4'b0000;
            2'd1:    m = 4'b1011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0101;
        endcase
        {e.sm, e.sd, e.bm, e.bd} = m;
        for (int i = 0; i < 7; i++) begin
            if (a == tbl_a[i]) {e.sector, e.sm, e.sd, e.bm, e.bd} = tbl_v[i];
        end
        e.sc = 1'b0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    // Step-7 datapath: always ready, completes 3 cycles after each accept.
    assign bus7.issue_ready = 1'b1;
    assign bus7.proj_done   = (pd_cnt7 == 1);
    always @(posedge clk) begin
        if (bus7.issue_valid && bus7.issue_ready) pd_cnt7 <= 3;
        else if (pd_cnt7 > 0)                     pd_cnt7 <= pd_cnt7 - 1;
    end

    always @(negedge clk) begin
        exp_t act, e;
        if (bus.issue_valid && bus.issue_ready) begin
            act = '{bus.angle, bus.sector, bus.scan_mode, bus.scan_direction,
                    bus.buff_step_mode, bus.buff_step_direction, bus.sector_change};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL issue unexpected got a=%0d", act.angle);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL issue got a=%0d s=%0d m=%b sc=%b exp a=%0d s=%0d m=%b sc=%b",
                             act.angle, act.sector, {act.sm, act.sd, act.bm, act.bd}, act.sc,
                             e.angle, e.sector, {e.sm, e.sd, e.bm, e.bd}, e.sc);
                end
            end
        end
        if (bus7.issue_valid && bus7.issue_ready) begin
            n7++;
            act = '{{1'b0, bus7.angle}, bus7.sector, bus7.scan_mode, bus7.scan_direction,
                    bus7.buff_step_mode, bus7.buff_step_direction, bus7.sector_change};
            checks++;
            if (q7.size() == 0) begin
                errors++;
                $display("FAIL issue7 unexpected got a=%0d", act.angle);
            end else begin
                e = q7.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL issue7 got a=%0d s=%0d sc=%b exp a=%0d s=%0d sc=%b",
                             act.angle, act.sector, act.sc, e.angle, e.sector, e.sc);
                end
            end
        end
        if (sweep_done)  sd_cnt++;
        if (aborted)     ab_cnt++;
        if (sweep_done7) sd7_cnt++;
    end

    task automatic run_sweep(input int abort_at, input int bp_at, input int start_at,
                             input int reset_at);
        int         a;
        int         t;
        bit         first;
        logic [1:0] prev;
        exp_t       e;
        a     = 0;
        first = 1'b1;
        prev  = 2'd0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (1) begin
            e    = model(a);
            e.sc = first || (e.sector != prev);
            prev  = e.sector;
            first = 1'b0;
            q.push_back(e);
            t = 0;
            while (!bus.issue_valid && t < 8) begin
                @(posedge clk); #1;
                t++;
            end
            chk("issue_latency", t, 1);
            if (!bus.issue_valid) return;
            if (a == reset_at) begin
                bus.issue_ready = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_valid", bus.issue_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_angle", bus.angle, 0);
                chk("rst_sector", bus.sector, 0);
                reset = 1'b0;
                bus.issue_ready = 1'b1;
                e = q.pop_back();
                return;
            end
            if (a == bp_at) begin
                bus.issue_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("bp_valid", bus.issue_valid, 1);
                    chk("bp_angle", bus.angle, bp_at);
                end
                bus.issue_ready = 1'b1;
            end
            @(posedge clk); #1;
            chk("valid_drop", bus.issue_valid, 0);
            @(posedge clk); #1;
            if (a == start_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            bus.proj_done = 1'b1;
            abort = (a == abort_at);
            @(posedge clk); #1;
            bus.proj_done = 1'b0;
            if (abort) begin
                abort = 1'b0;
                chk("abort_pulse", aborted, 1);
                chk("abort_no_done", sweep_done, 0);
                chk("abort_busy", busy, 0);
                chk("abort_valid", bus.issue_valid, 0);
                @(posedge clk); #1;
                chk("abort_pulse_end", aborted, 0);
                return;
            end
            if (a + 1 >= 180) begin
                chk("sweep_done_pulse", sweep_done, 1);
                chk("sweep_busy_low", busy, 0);
                chk("sweep_last_angle", bus.angle, 179);
                @(posedge clk); #1;
                chk("sweep_done_end", sweep_done, 0);
                return;
            end
            a++;
        end
    endtask

    initial begin
        int         t;
        bit         first;
        logic [1:0] prev;
        exp_t       e;
        start = 1'b0; abort = 1'b0; reset = 1'b1;
        start7 = 1'b0; abort7 = 1'b0; reset7 = 1'b1;
        bus.issue_ready = 1'b1;
        bus.proj_done   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", bus.issue_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_angle", bus.angle, 0);
        chk("reset_sector", bus.sector, 0);
        chk("reset_modes", {bus.scan_mode, bus.scan_direction, bus.buff_step_mode,
                            bus.buff_step_direction}, 0);
        chk("reset_sc", bus.sector_change, 0);
        chk("reset_done", {sweep_done, aborted}, 0);

        first = 1'b1;
        prev  = 2'd0;
        for (int a = 0; a < 180; a += 7) begin
            e    = model(a);
            e.sc = first || (e.sector != prev);
            prev  = e.sector;
            first = 1'b0;
            q7.push_back(e);
        end

        reset = 1'b0; reset7 = 1'b0;
        @(posedge clk); #1;
        start7 = 1'b1;
        bus.proj_done = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start7 = 1'b0;
        bus.proj_done = 1'b0;
        abort = 1'b0;
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_abort", aborted, 0);
        chk("idle_ignore_valid", bus.issue_valid, 0);
        @(posedge clk); #1;
        chk("idle_still_idle", bus.issue_valid, 0);

        run_sweep(-1, 10, 20, -1);
        chk("sweep_done_count", sd_cnt, 1);
        run_sweep(60, -1, -1, -1);
        chk("abort_count", ab_cnt, 1);
        chk("abort_no_sweep_done", sd_cnt, 1);
        run_sweep(3, -1, -1, -1);
        chk("abort_count2", ab_cnt, 2);
        run_sweep(-1, -1, -1, 50);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_no_pulse", ab_cnt * 10 + sd_cnt, 21);
        chk("reset_idle_busy", busy, 0);

        t = 0;
        while (sd7_cnt == 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("step7_sweep_done", sd7_cnt, 1);
        chk("step7_issues", n7, 26);
        chk("step7_busy", busy7, 0);
        chk("step7_last_angle", bus7.angle, 175);
        chk("queue_empty", q.size(), 0);
        chk("queue7_empty", q7.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
